// File: rtl/ariane_pkg.sv
// Shared types and constants for the shared functional-unit sequencer.
//   shared_fu_state_e : sequencer FSM states
//   SHARED_FU_CNT_W   : width of the contention counter
package ariane_pkg;

    localparam int unsigned SHARED_FU_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DRAIN = 2'd3
    } shared_fu_state_e;

endpackage

// File: rtl/shared_fu_prio_sel.sv
// Lowest-index-first one-hot picker.
// Ports:
//   en_i        : picking enabled; when low the ack vector is zero
//   req_valid_i : request per port (bit 0 = oldest)
//   ack_o       : one-hot (or zero) grant, combinational
//   idx_o       : encoded index of the granted port (0 when none)
module shared_fu_prio_sel #(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned IDX_W    = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
    input  logic                en_i,
    input  logic [NR_PORTS-1:0] req_valid_i,
    output logic [NR_PORTS-1:0] ack_o,
    output logic [IDX_W-1:0]    idx_o
);

    // Walk upward and stop at the first valid port so younger ports never win.
    always_comb begin
        logic found;
        ack_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NR_PORTS); i++) begin
            if (en_i && req_valid_i[i] && !found) begin
                ack_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_fu_sequencer.sv
// Sequences one shared iterative FU between the issue ports of a dual-issue stage.
// Optional feature: define SHARED_FU_PERF_EN to build the contention counter.
// Ports:
//   clk_i, rst_i (async, active-high), flush_i
//   req_valid_i / req_data_i / req_trans_id_i : per-port requests, req_ack_o (combinational)
//   fu_valid_o / fu_data_o / fu_trans_id_o / fu_ready_i : FU issue handshake
//   fu_done_i / fu_result_i                   : FU completion
//   wb_valid_o / wb_trans_id_o / wb_result_o  : registered writeback
//   busy_o                                    : sequencer not idle
//   conflict_cnt_o                            : cycles with a request but no ack (0 when disabled)
module shared_fu_sequencer
    import ariane_pkg::*;
#(
    parameter int unsigned NR_PORTS      = 2,
    parameter int unsigned DATA_W        = 200,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic [NR_PORTS-1:0]               req_valid_i,
    input  logic [NR_PORTS*DATA_W-1:0]        req_data_i,
    input  logic [NR_PORTS*TRANS_ID_BITS-1:0] req_trans_id_i,
    output logic [NR_PORTS-1:0]               req_ack_o,
    output logic                              fu_valid_o,
    output logic [DATA_W-1:0]                 fu_data_o,
    output logic [TRANS_ID_BITS-1:0]          fu_trans_id_o,
    input  logic                              fu_ready_i,
    input  logic                              fu_done_i,
    input  logic [63:0]                       fu_result_i,
    output logic                              wb_valid_o,
    output logic [TRANS_ID_BITS-1:0]          wb_trans_id_o,
    output logic [63:0]                       wb_result_o,
    output logic                              busy_o,
    output logic [31:0]                       conflict_cnt_o
);

    localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    shared_fu_state_e state_q, state_d;

    logic [DATA_W-1:0]        data_arr [NR_PORTS];
    logic [TRANS_ID_BITS-1:0] id_arr   [NR_PORTS];
    logic [IDX_W-1:0]         sel_idx;
    logic                     prio_en;
    logic                     wb_take;

    logic [DATA_W-1:0]        op_data_q;
    logic [TRANS_ID_BITS-1:0] op_id_q;
    logic                     fu_valid_q;
    logic                     busy_q;
    logic                     wb_valid_q;
    logic [TRANS_ID_BITS-1:0] wb_id_q;
    logic [63:0]              wb_result_q;

    // Unpack the flat per-port request buses.
    for (genvar p = 0; p < int'(NR_PORTS); p++) begin : g_split
        assign data_arr[p] = req_data_i[p*DATA_W +: DATA_W];
        assign id_arr[p]   = req_trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS];
    end

    // Only an idle, unflushed sequencer may accept a request.
    assign prio_en = (state_q == IDLE) && !flush_i;

    shared_fu_prio_sel #(
        .NR_PORTS (NR_PORTS),
        .IDX_W    (IDX_W)
    ) u_prio_sel (
        .en_i        (prio_en),
        .req_valid_i (req_valid_i),
        .ack_o       (req_ack_o),
        .idx_o       (sel_idx)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a flush after the FU took the op must still absorb its result.
    always_comb begin
        state_d = state_q;
        wb_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_ack_o) state_d = ISSUE;
            end
            ISSUE: begin
                if (flush_i)         state_d = fu_ready_i ? DRAIN : IDLE;
                else if (fu_ready_i) state_d = BUSY;
            end
            BUSY: begin
                if (fu_done_i) begin
                    state_d = IDLE;
                    wb_take = !flush_i;
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fu_done_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, registered status and writeback.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_data_q   <= '0;
            op_id_q     <= '0;
            fu_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_id_q     <= '0;
            wb_result_q <= '0;
        end else begin
            if (|req_ack_o) begin
                op_data_q <= data_arr[sel_idx];
                op_id_q   <= id_arr[sel_idx];
            end
            fu_valid_q <= (state_d == ISSUE);
            busy_q     <= (state_d != IDLE);
            wb_valid_q <= wb_take;
            if (wb_take) begin
                wb_id_q     <= op_id_q;
                wb_result_q <= fu_result_i;
            end
        end
    end

    assign fu_valid_o    = fu_valid_q;
    assign fu_data_o     = op_data_q;
    assign fu_trans_id_o = op_id_q;
    assign busy_o        = busy_q;
    assign wb_valid_o    = wb_valid_q;
    assign wb_trans_id_o = wb_id_q;
    assign wb_result_o   = wb_result_q;

`ifdef SHARED_FU_PERF_EN
    logic [SHARED_FU_CNT_W-1:0] conflict_cnt_q;

    // Saturating count of cycles where someone wanted the FU but nobody got it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            conflict_cnt_q <= '0;
        end else if ((|req_valid_i) && !(|req_ack_o) && (conflict_cnt_q != '1)) begin
            conflict_cnt_q <= conflict_cnt_q + SHARED_FU_CNT_W'(1);
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
`else
    assign conflict_cnt_o = '0;
`endif

    // A completion with nothing outstanding at the FU is a protocol error.
    a_done_only_when_outstanding: assert property (
        @(posedge clk_i) disable iff (rst_i)
        fu_done_i |-> (state_q == BUSY || state_q == DRAIN)
    ) else $error("fu_done_i while no FU operation outstanding");

endmodule

// File: tb/tb_shared_fu_sequencer.sv
module tb_shared_fu_sequencer;

    localparam int unsigned NP  = 2;
    localparam int unsigned DW  = 200;
    localparam int unsigned IDW = 3;

    logic               clk;
    logic               rst;
    logic               flush;
    logic [NP-1:0]      req_valid;
    logic [NP*DW-1:0]   req_data;
    logic [NP*IDW-1:0]  req_id;
    logic [NP-1:0]      req_ack;
    logic               fu_valid;
    logic [DW-1:0]      fu_data;
    logic [IDW-1:0]     fu_id;
    logic               fu_ready;
    logic               fu_done;
    logic [63:0]        fu_result;
    logic               wb_valid;
    logic [IDW-1:0]     wb_id;
    logic [63:0]        wb_result;
    logic               busy;
    logic [31:0]        conflict_cnt;

    int checks = 0;
    int errors = 0;

    shared_fu_sequencer #(
        .NR_PORTS      (NP),
        .DATA_W        (DW),
        .TRANS_ID_BITS (IDW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_trans_id_i (req_id),
        .req_ack_o      (req_ack),
        .fu_valid_o     (fu_valid),
        .fu_data_o      (fu_data),
        .fu_trans_id_o  (fu_id),
        .fu_ready_i     (fu_ready),
        .fu_done_i      (fu_done),
        .fu_result_i    (fu_result),
        .wb_valid_o     (wb_valid),
        .wb_trans_id_o  (wb_id),
        .wb_result_o    (wb_result),
        .busy_o         (busy),
        .conflict_cnt_o (conflict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_id    = '0;
        fu_ready  = 1'b0;
        fu_done   = 1'b0;
        fu_result = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r = '0;
        for (int i = 0; i < 7; i++) r = {r[DW-33:0], 32'($urandom)};
        return r;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (fu_valid !== 1'b0) begin errors++; $display("FAIL reset_fu_valid got %b exp 0", fu_valid); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (conflict_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", conflict_cnt); end
        checks++; if (fu_data !== '0 || fu_id !== '0) begin errors++; $display("FAIL reset_fu_regs got %h/%h exp 0/0", fu_data, fu_id); end
        checks++; if (wb_id !== '0 || wb_result !== '0) begin errors++; $display("FAIL reset_wb_regs got %h/%h exp 0/0", wb_id, wb_result); end
    endtask

    task automatic test_single_op();
        do_reset();
        req_valid = 2'b01; req_id[2:0] = 3'd5; req_data[DW-1:0] = DW'(8'hA5);
        #1;
        checks++; if (req_ack !== 2'b01) begin errors++; $display("FAIL single_ack got %b exp 01", req_ack); end
        step();
        req_valid = '0;
        checks++; if (fu_valid !== 1'b1 || fu_id !== 3'd5 || fu_data !== DW'(8'hA5))
            begin errors++; $display("FAIL single_issue got v=%b id=%0d d=%h exp 1/5/a5", fu_valid, fu_id, fu_data); end
        fu_ready = 1'b1;
        #1;
        checks++; if (req_ack !== 2'b00) begin errors++; $display("FAIL single_ack_issue got %b exp 00", req_ack); end
        step();
        fu_ready = 1'b0;
        checks++; if (fu_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_busy got v=%b b=%b exp 0/1", fu_valid, busy); end
        step();
        fu_done = 1'b1; fu_result = 64'h1234;
        step();
        fu_done = 1'b0; fu_result = '0;
        checks++; if (wb_valid !== 1'b1 || wb_id !== 3'd5 || wb_result !== 64'h1234)
            begin errors++; $display("FAIL single_wb got v=%b id=%0d r=%h exp 1/5/1234", wb_valid, wb_id, wb_result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", busy); end
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL single_wb_pulse got %b exp 0", wb_valid); end
    endtask

    task automatic test_ordering();
        do_reset();
        req_valid = 2'b11; req_id = {3'd3, 3'd2};
        #1;
        checks++; if (req_ack !== 2'b01) begin errors++; $display("FAIL order_ack0 got %b exp 01", req_ack); end
        step();
        req_valid = 2'b10; fu_ready = 1'b1;
        #1;
        checks++; if (req_ack !== 2'b00) begin errors++; $display("FAIL order_pending got %b exp 00", req_ack); end
        step();
        fu_ready = 1'b0; fu_done = 1'b1; fu_result = 64'hAAAA;
        step();
        fu_done = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_id !== 3'd2 || wb_result !== 64'hAAAA)
            begin errors++; $display("FAIL order_wb0 got v=%b id=%0d r=%h exp 1/2/aaaa", wb_valid, wb_id, wb_result); end
        checks++; if (req_ack !== 2'b10) begin errors++; $display("FAIL order_ack1 got %b exp 10", req_ack); end
        step();
        req_valid = '0; fu_ready = 1'b1;
        checks++; if (fu_valid !== 1'b1 || fu_id !== 3'd3) begin errors++; $display("FAIL order_issue1 got v=%b id=%0d exp 1/3", fu_valid, fu_id); end
        step();
        fu_ready = 1'b0; fu_done = 1'b1; fu_result = 64'hBBBB;
        step();
        fu_done = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_id !== 3'd3 || wb_result !== 64'hBBBB)
            begin errors++; $display("FAIL order_wb1 got v=%b id=%0d r=%h exp 1/3/bbbb", wb_valid, wb_id, wb_result); end
    endtask

    task automatic test_flush_issue();
        int wb_seen;
        do_reset();
        req_valid = 2'b01; req_id[2:0] = 3'd1;
        step();
        req_valid = '0; flush = 1'b1; fu_ready = 1'b0;
        step();
        flush = 1'b0;
        checks++; if (fu_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_issue_idle got v=%b b=%b exp 0/0", fu_valid, busy); end
        wb_seen = 0;
        for (int i = 0; i < 4; i++) begin step(); if (wb_valid) wb_seen++; end
        checks++; if (wb_seen != 0) begin errors++; $display("FAIL flush_issue_nowb got %0d exp 0", wb_seen); end
        // Flush while the FU accepts: result must be drained silently.
        req_valid = 2'b01;
        step();
        req_valid = '0; flush = 1'b1; fu_ready = 1'b1;
        step();
        flush = 1'b0; fu_ready = 1'b0;
        checks++; if (busy !== 1'b1 || fu_valid !== 1'b0) begin errors++; $display("FAIL flush_drain got b=%b v=%b exp 1/0", busy, fu_valid); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_ignores_flush got %b exp 1", busy); end
        fu_done = 1'b1; fu_result = 64'hDEAD;
        step();
        fu_done = 1'b0;
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL drain_done got wb=%b b=%b exp 0/0", wb_valid, busy); end
    endtask

    task automatic test_flush_busy();
        do_reset();
        req_valid = 2'b01;
        step();
        req_valid = '0; fu_ready = 1'b1;
        step();
        fu_ready = 1'b0; flush = 1'b1; fu_done = 1'b1; fu_result = 64'h55;
        step();
        flush = 1'b0; fu_done = 1'b0;
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_busy_done got wb=%b b=%b exp 0/0", wb_valid, busy); end
        req_valid = 2'b01;
        #1;
        checks++; if (req_ack !== 2'b01) begin errors++; $display("FAIL flush_busy_reack got %b exp 01", req_ack); end
        step();
        req_valid = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req_valid = 2'b01;
        step();
        req_valid = '0; fu_ready = 1'b1;
        step();
        fu_ready = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy got %b exp 1", busy); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || fu_valid !== 1'b0 || wb_valid !== 1'b0)
            begin errors++; $display("FAIL areset_async got b=%b v=%b wb=%b exp 0/0/0", busy, fu_valid, wb_valid); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_perf();
        logic [31:0] exp_cnt;
        do_reset();
        req_valid = 2'b01;
        step();
        req_valid = 2'b10; fu_ready = 1'b0;
        repeat (10) step();
        req_valid = '0;
`ifdef SHARED_FU_PERF_EN
        exp_cnt = 32'd10;
`else
        exp_cnt = 32'd0;
`endif
        checks++; if (conflict_cnt !== exp_cnt) begin errors++; $display("FAIL perf_cnt got %0d exp %0d", conflict_cnt, exp_cnt); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (conflict_cnt !== exp_cnt) begin errors++; $display("FAIL perf_cnt_flush got %0d exp %0d", conflict_cnt, exp_cnt); end
    endtask

    // Transaction-level model: an op either waits for the FU, is being computed, or nothing is held.
    task automatic test_random();
        logic          held;
        logic          computing;
        logic          keep;
        logic [IDW-1:0] m_id;
        logic [DW-1:0]  m_data;
        logic [NP-1:0]  exp_ack;
        logic          exp_wb;
        logic [IDW-1:0] exp_wb_id;
        logic [63:0]   exp_wb_res;
        logic [31:0]   exp_cnt;
        int            first;
        do_reset();
        held = 0; computing = 0; keep = 0; m_id = '0; m_data = '0; exp_cnt = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            req_valid = NP'($urandom_range(0, 3));
            for (int p = 0; p < int'(NP); p++) begin
                req_data[p*DW +: DW]   = rand_data();
                req_id[p*IDW +: IDW]   = IDW'($urandom);
            end
            flush     = ($urandom_range(0, 7) == 0);
            fu_ready  = 1'($urandom);
            fu_done   = computing && ($urandom_range(0, 2) == 0);
            fu_result = {32'($urandom), 32'($urandom)};
            #1;
            exp_ack = '0;
            first = -1;
            if (!held && !computing && !flush) begin
                for (int p = 0; p < int'(NP); p++) if (req_valid[p] && first < 0) first = p;
                if (first >= 0) exp_ack[first] = 1'b1;
            end
            checks++; if (req_ack !== exp_ack) begin errors++; $display("FAIL rnd_ack cyc %0d got %b exp %b", cyc, req_ack, exp_ack); end
            exp_wb = 0; exp_wb_id = '0; exp_wb_res = '0;
            if ((|req_valid) && first < 0) exp_cnt++;
            if (first >= 0) begin
                held = 1; m_id = req_id[first*IDW +: IDW]; m_data = req_data[first*DW +: DW];
            end else if (held) begin
                if (fu_ready) begin held = 0; computing = 1; keep = !flush; end
                else if (flush) held = 0;
            end else if (computing) begin
                if (fu_done) begin
                    computing = 0;
                    exp_wb = keep && !flush; exp_wb_id = m_id; exp_wb_res = fu_result;
                end else if (flush) keep = 0;
            end
            step();
            checks++; if (fu_valid !== held || busy !== (held || computing))
                begin errors++; $display("FAIL rnd_state cyc %0d got v=%b b=%b exp %b/%b", cyc, fu_valid, busy, held, held || computing); end
            if (held) begin
                checks++; if (fu_data !== m_data || fu_id !== m_id)
                    begin errors++; $display("FAIL rnd_fu_op cyc %0d got id=%0d exp id=%0d", cyc, fu_id, m_id); end
            end
            checks++; if (wb_valid !== exp_wb) begin errors++; $display("FAIL rnd_wb_valid cyc %0d got %b exp %b", cyc, wb_valid, exp_wb); end
            if (exp_wb) begin
                checks++; if (wb_id !== exp_wb_id || wb_result !== exp_wb_res)
                    begin errors++; $display("FAIL rnd_wb cyc %0d got %0d/%h exp %0d/%h", cyc, wb_id, wb_result, exp_wb_id, exp_wb_res); end
            end
`ifdef SHARED_FU_PERF_EN
            checks++; if (conflict_cnt !== exp_cnt) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", cyc, conflict_cnt, exp_cnt); end
`else
            checks++; if (conflict_cnt !== 32'd0) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d exp 0", cyc, conflict_cnt); end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_op();
        test_ordering();
        test_flush_issue();
        test_flush_busy();
        test_async_reset();
        test_perf();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
